sync_fifo: RTL and testbench

- Single-clock byte FIFO. Same write/read port semantics as async_fifo, for paths where producer and consumer share one clock.
- Typical use: buffering between the FT2232 FIFO engine and the control logic when both run on the same clock.
- Depth is 2^ASIZE entries. It provides full, almost-full and empty flags. Read data is first-word-fall-through.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 37 +++
 rtl/sync_fifo.sv | 110 +++++++++++
 tb/tb_sync_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock byte FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_fifo_pkg;

  // Default geometry: 64 entries of one byte each.
  localparam int SYNC_FIFO_ASIZE = 6;
  localparam int SYNC_FIFO_DSIZE = 8;

  // Occupancy at or above which the almost-full flag is raised (DEPTH-1).
  function automatic int awfull_thresh(input int asize);
    return (1 << asize) - 1;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
// Latency: write visible on the read port right after the writing edge; read is combinational.
// Backpressure: none; the caller gates 'we' and guarantees address validity.
//
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write address, wdata - write data
//   raddr  - read address,  rdata - read data (combinational)
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int ASIZE = SYNC_FIFO_ASIZE,
  parameter int DSIZE = SYNC_FIFO_DSIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  // Storage is deliberately not reset so it maps onto plain RAM cells.
  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO with full/almost-full/empty flags.
// Latency: a write at edge N is visible on rd_data_o (rd_empty_o low) right after edge N.
// Backpressure: writes while full and reads while empty are dropped; flags are registered.
//
// Optional feature: define SYNC_FIFO_OVERFLOW_EN to add sticky wr_overflow_o / rd_underflow_o.
//
// Ports:
//   clk_i, reset_n_i      - clock and synchronous active-low reset
//   wr_en_i, wr_data_i    - push request and data
//   wr_full_o             - FIFO holds DEPTH entries
//   wr_awfull_o           - FIFO holds at least DEPTH-1 entries
//   rd_en_i               - pop request
//   rd_data_o, rd_empty_o - head entry (valid while not empty) and empty flag
//   wr_overflow_o         - (optional) sticky: a push was attempted while full
//   rd_underflow_o        - (optional) sticky: a pop was attempted while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int ASIZE = SYNC_FIFO_ASIZE,
  parameter int DSIZE = SYNC_FIFO_DSIZE
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wr_data_i,
  output logic             wr_full_o,
  output logic             wr_awfull_o,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rd_data_o,
`ifdef SYNC_FIFO_OVERFLOW_EN
  output logic             rd_empty_o,
  output logic             wr_overflow_o,
  output logic             rd_underflow_o
`else
  output logic             rd_empty_o
`endif
);

  // Pointer-width constants; the extra MSB separates full from empty.
  localparam int             AWF_INT   = awfull_thresh(ASIZE);
  localparam logic [ASIZE:0] DEPTH_CNT = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AWF_CNT   = AWF_INT[ASIZE:0];
  localparam logic [ASIZE:0] ZERO_CNT  = '0;

  logic [ASIZE:0] wr_ptr;
  logic [ASIZE:0] rd_ptr;
  logic [ASIZE:0] wr_ptr_nxt;
  logic [ASIZE:0] rd_ptr_nxt;
  logic [ASIZE:0] count_nxt;
  logic           wr_acc;
  logic           rd_acc;

  // Acceptance uses the registered flags, which are exact for the current
  // pointers because they were computed from these pointers' next-state.
  assign wr_acc = wr_en_i && !wr_full_o;
  assign rd_acc = rd_en_i && !rd_empty_o;

  assign wr_ptr_nxt = wr_ptr + {{ASIZE{1'b0}}, wr_acc};
  assign rd_ptr_nxt = rd_ptr + {{ASIZE{1'b0}}, rd_acc};

  // Modulo 2^(ASIZE+1) subtraction gives the occupancy across pointer wraps.
  assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_full_o   <= 1'b0;
      wr_awfull_o <= 1'b0;
      rd_empty_o  <= 1'b1;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_full_o   <= (count_nxt == DEPTH_CNT);
      wr_awfull_o <= (count_nxt >= AWF_CNT);
      rd_empty_o  <= (count_nxt == ZERO_CNT);
    end
  end

`ifdef SYNC_FIFO_OVERFLOW_EN
  // Sticky error indicators for status LEDs; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_overflow_o  <= 1'b0;
      rd_underflow_o <= 1'b0;
    end else begin
      if (wr_en_i && wr_full_o) begin
        wr_overflow_o <= 1'b1;
      end
      if (rd_en_i && rd_empty_o) begin
        rd_underflow_o <= 1'b1;
      end
    end
  end
`endif

  // Reset wins over a concurrent write, so the RAM is not touched in reset.
  sync_fifo_mem #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE)
  ) u_mem (
    .clk   (clk_i),
    .we    (wr_acc && reset_n_i),
    .waddr (wr_ptr[ASIZE-1:0]),
    .wdata (wr_data_i),
    .raddr (rd_ptr[ASIZE-1:0]),
    .rdata (rd_data_o)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model plus directed vectors.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sync_fifo;

  localparam int DEPTH = 64;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       wr_awfull;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
`ifdef SYNC_FIFO_OVERFLOW_EN
  logic       wr_overflow;
  logic       rd_underflow;
`endif

  int tests = 0;
  int fails = 0;

  sync_fifo dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .wr_full_o   (wr_full),
    .wr_awfull_o (wr_awfull),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
`ifdef SYNC_FIFO_OVERFLOW_EN
    .rd_empty_o     (rd_empty),
    .wr_overflow_o  (wr_overflow),
    .rd_underflow_o (rd_underflow)
`else
    .rd_empty_o  (rd_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  byte unsigned mq[$];
  bit           m_ovf = 1'b0;
  bit           m_und = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_und = 1'b0;
    end else begin
      bit w;
      bit r;
      w = wr_en && (mq.size() < DEPTH);
      r = rd_en && (mq.size() > 0);
      if (wr_en && mq.size() == DEPTH) m_ovf = 1'b1;
      if (rd_en && mq.size() == 0)     m_und = 1'b1;
      if (r) void'(mq.pop_front());
      if (w) mq.push_back(wr_data);
    end
    chk_en = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_empty",  {31'd0, rd_empty},  {31'd0, mq.size() == 0});
      chk("model_full",   {31'd0, wr_full},   {31'd0, mq.size() == DEPTH});
      chk("model_awfull", {31'd0, wr_awfull}, {31'd0, mq.size() >= DEPTH - 1});
      if (mq.size() > 0) chk("model_data", {24'd0, rd_data}, {24'd0, mq[0]});
`ifdef SYNC_FIFO_OVERFLOW_EN
      chk("model_ovf", {31'd0, wr_overflow},  {31'd0, m_ovf});
      chk("model_und", {31'd0, rd_underflow}, {31'd0, m_und});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    int occ;
    int k;
    logic w;
    logic r;

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

    // Reset held two cycles with a write request pending.
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h11, 1'b0);
    chk("rst_empty",  {31'd0, rd_empty},  32'd1);
    chk("rst_full",   {31'd0, wr_full},   32'd0);
    chk("rst_awfull", {31'd0, wr_awfull}, 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("rst_nothing_stored", {31'd0, rd_empty}, 32'd1);

    // Single byte in and out.
    cyc(1'b1, 8'hA5, 1'b0);
    chk("single_empty", {31'd0, rd_empty}, 32'd0);
    chk("single_data",  {24'd0, rd_data},  32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single_popped", {31'd0, rd_empty}, 32'd1);

    // Fill to DEPTH.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 61) chk("fill62_awfull", {31'd0, wr_awfull}, 32'd0);
      if (i == 62) begin
        chk("fill63_awfull", {31'd0, wr_awfull}, 32'd1);
        chk("fill63_full",   {31'd0, wr_full},   32'd0);
      end
    end
    chk("fill64_full", {31'd0, wr_full}, 32'd1);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("drop65_full", {31'd0, wr_full}, 32'd1);
    chk("drop65_head", {24'd0, rd_data}, 32'h00);

    // Full with both enables: read wins, write dropped.
    cyc(1'b1, 8'hEE, 1'b1);
    chk("fullboth_full",   {31'd0, wr_full},   32'd0);
    chk("fullboth_awfull", {31'd0, wr_awfull}, 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_order", {24'd0, rd_data}, i);
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", {31'd0, rd_empty}, 32'd1);

    // Empty with both enables: write accepted, read ignored.
    cyc(1'b1, 8'h5A, 1'b1);
    chk("emptyboth_empty", {31'd0, rd_empty}, 32'd0);
    chk("emptyboth_data",  {24'd0, rd_data},  32'h5A);
    cyc(1'b0, 8'h00, 1'b1);
    chk("emptyboth_pop", {31'd0, rd_empty}, 32'd1);

    // Streaming across pointer wraps with 1..10 entries resident.
    sent = 0; recv = 0; occ = 0; k = 0;
    while (recv < 200 && k < 3000) begin
      w = (sent < 200) && (occ < 10) && (k % 3 != 2);
      r = ((occ > 1) || (sent == 200 && occ > 0)) && (k % 5 != 4);
      if (r) chk("stream_data", {24'd0, rd_data}, recv & 8'hFF);
      cyc(w, 8'(sent), r);
      sent += int'(w);
      recv += int'(r);
      occ  += int'(w) - int'(r);
      k++;
    end
    chk("stream_complete", recv, 200);
    chk("stream_empty", {31'd0, rd_empty}, 32'd1);

`ifdef SYNC_FIFO_OVERFLOW_EN
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    chk("sticky_rst_ovf", {31'd0, wr_overflow},  32'd0);
    chk("sticky_rst_und", {31'd0, rd_underflow}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("und_set", {31'd0, rd_underflow}, 32'd1);
    chk("und_ovf_clear", {31'd0, wr_overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("ovf_before", {31'd0, wr_overflow}, 32'd0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", {31'd0, wr_overflow}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("ovf_sticky", {31'd0, wr_overflow},  32'd1);
    chk("und_sticky", {31'd0, rd_underflow}, 32'd1);
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    chk("ovf_cleared", {31'd0, wr_overflow},  32'd0);
    chk("und_cleared", {31'd0, rd_underflow}, 32'd0);
`endif

    cyc(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, limit %0t", $time);
    $fatal(1);
  end

endmodule : tb_sync_fifo
